l2_out_pingpong_buf: RTL
========================

Name: l2_out_pingpong_buf

Overview:
- Staging buffer between the layer-2 processing unit and the layer-3 input fetch.
- Layer 2 produces its 64 activations as two 32-lane, 8-bit vectors. The low half arrives on the first temp write strobe and the high half on the second.
- This block captures both halves into one of two ping-pong banks, then presents a completed frame to layer 3 as a byte-addressed, 1-cycle-latency read port.
- Layer 2 can therefore fill the next frame while layer 3 consumes the current one.

Parameters:
- DATA_WIDTH, 8, bits per activation.
- LANES, 32, activations per layer-2 write vector.
- ADDR_WIDTH, 6, byte address width; must equal log2(2*LANES).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- wr_lo_en_i  in  1  write strobe for the low half (activations 0..LANES-1).
- wr_hi_en_i  in  1  write strobe for the high half (activations LANES..2*LANES-1).
- din_i  in  LANES*DATA_WIDTH  write vector; lane k = din_i[k*DATA_WIDTH +: DATA_WIDTH].
- wr_ready_o  out  1  current write bank can accept data.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_WIDTH  byte address within the frame.
- dout_o  out  DATA_WIDTH  read data, registered.
- rd_valid_o  out  1  dout_o updated this cycle.
- frame_valid_o  out  1  current read bank holds a complete frame.
- rd_release_i  in  1  layer 3 has finished with the current frame.
- overflow_o  out  1  sticky: a write was dropped because wr_ready_o was low.
- order_err_o  out  1  sticky: a high-half write arrived into an EMPTY bank.

Behaviour:
- Storage: 2 banks x 2*LANES x DATA_WIDTH registers. Pointers wr_bank and rd_bank are 1 bit each.
- Per-bank state is one of EMPTY, HALF, FULL.
- Reset (rst_i=1 at a clock edge) sets:
  - both banks EMPTY; wr_bank=0, rd_bank=0;
  - dout_o=0, rd_valid_o=0, overflow_o=0, order_err_o=0;
  - therefore wr_ready_o=1 and frame_valid_o=0.
  - Stored data is not cleared; it becomes don't-care.
  - A reset mid-frame discards any partial or complete frames.
- Combinational outputs:
  - wr_ready_o = (state[wr_bank] != FULL).
  - frame_valid_o = (state[rd_bank] == FULL).
- Write path; a strobe is accepted only when wr_ready_o=1:
  - wr_lo_en_i in EMPTY or HALF: write din_i lanes to bytes 0..LANES-1; state -> HALF. Repeating a low write in HALF overwrites the low half.
  - wr_hi_en_i in HALF: write lanes to bytes LANES..2*LANES-1; state -> FULL.
  - wr_hi_en_i in EMPTY alone: ignored; order_err_o set.
  - wr_lo_en_i and wr_hi_en_i in the same cycle: both halves are written from the same din_i and the state goes to FULL.
  - On the transition to FULL, wr_bank toggles at the same edge.
  - Any strobe while wr_ready_o=0: data dropped, no state change, overflow_o set.
- Read path:
  - rd_en_i=1 with frame_valid_o=1: on the next edge dout_o = bank[rd_bank][rd_addr_i] and rd_valid_o=1 for one cycle.
  - rd_en_i with frame_valid_o=0: dout_o holds its value and rd_valid_o=0.
- Release:
  - rd_release_i with frame_valid_o=1: state[rd_bank] -> EMPTY and rd_bank toggles.
  - rd_release_i with frame_valid_o=0: ignored.
  - rd_en_i and rd_release_i in the same cycle: the read uses the pre-release bank and returns valid data.
- Simultaneous events:
  - Release of one bank and a write to the other bank in the same cycle: both take effect.
  - If both banks are FULL, wr_bank == rd_bank. A release frees that bank and wr_ready_o rises the following cycle. A write in the release cycle is still dropped.
- Latency:
  - Write to frame_valid_o: 1 cycle after the completing write, if that bank is the read bank.
  - Read: 1 cycle.
- Sticky flags clear only on reset.

Test Plan:
- Single frame: write lo with lane k = k, then hi with lane k = 0x80+k. Expect frame_valid_o=1 on the next cycle. Reading addresses 0, 31, 32, 63 gives 0x00, 0x1F, 0x80, 0x9F, each with a 1-cycle rd_valid_o pulse.
- Ping-pong and full: write frames A and B with no release. Expect wr_ready_o=0 and frame_valid_o=1 showing A. A third lo write is dropped and sets overflow_o. After release, reads return B data and wr_ready_o returns to 1.
- Ordering: hi write into an EMPTY bank sets order_err_o and leaves the state EMPTY. A lo write followed by two lo writes ending in 0x55 pattern then hi gives byte 5 = 0x55.
- Same-cycle events:
  - lo and hi strobes together with din_i = 0xAA… produce FULL in one cycle with all 64 bytes = 0xAA.
  - rd_en_i and rd_release_i together return valid data, then frame_valid_o drops.
- Reset mid-operation: assert rst_i with bank 0 FULL and bank 1 HALF. Expect all outputs at reset values, wr_ready_o=1, frame_valid_o=0, flags cleared, and new frames are accepted into bank 0.
- Invalid-read guard: rd_en_i with frame_valid_o=0 leaves rd_valid_o=0 and dout_o unchanged. rd_release_i while empty has no effect.

Source files
------------

// File: rtl/l2_out_pingpong_buf_if.sv
// Layer-2 output staging bus: layer-2 write side, layer-3 read/release side
// and the sticky error flags.
//   wr_lo_en_i / wr_hi_en_i / din_i : half-frame write strobes and lane vector
//   wr_ready_o                      : write bank can take data
//   rd_en_i / rd_addr_i             : byte read request within the frame
//   dout_o / rd_valid_o             : registered read data and its strobe
//   frame_valid_o / rd_release_i    : frame presented / frame consumed
//   overflow_o / order_err_o        : sticky error flags
interface l2_out_pingpong_buf_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 32,
   parameter int ADDR_WIDTH = 6
);
   logic                        wr_lo_en_i;
   logic                        wr_hi_en_i;
   logic [LANES*DATA_WIDTH-1:0] din_i;
   logic                        wr_ready_o;
   logic                        rd_en_i;
   logic [ADDR_WIDTH-1:0]       rd_addr_i;
   logic [DATA_WIDTH-1:0]       dout_o;
   logic                        rd_valid_o;
   logic                        frame_valid_o;
   logic                        rd_release_i;
   logic                        overflow_o;
   logic                        order_err_o;

   modport slave (
      input  wr_lo_en_i, wr_hi_en_i, din_i, rd_en_i, rd_addr_i, rd_release_i,
      output wr_ready_o, dout_o, rd_valid_o, frame_valid_o, overflow_o, order_err_o
   );

   modport master (
      output wr_lo_en_i, wr_hi_en_i, din_i, rd_en_i, rd_addr_i, rd_release_i,
      input  wr_ready_o, dout_o, rd_valid_o, frame_valid_o, overflow_o, order_err_o
   );
endinterface

// File: rtl/l2_out_pingpong_buf.sv
// Ping-pong staging buffer between layer-2 output and layer-3 input fetch.
// Two banks of 2*LANES bytes; layer 2 fills one bank half by half while
// layer 3 reads the other through a 1-cycle-latency byte port.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : l2_out_pingpong_buf_if slave (write, read, release, flags)
//
// Per-bank state:
//   state | meaning
//   EMPTY | no data captured for the current frame
//   HALF  | low half captured, waiting for the high half
//   FULL  | complete frame, owned by the read side until released
module l2_out_pingpong_buf #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 32,
   parameter int ADDR_WIDTH = 6
) (
   input logic                  clk_i,
   input logic                  rst_i,
   l2_out_pingpong_buf_if.slave bus
);
   localparam int BYTES = 2 * LANES;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } bank_state_e;

   bank_state_e           state_q [2];
   bank_state_e           state_d [2];
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic                  overflow_q, overflow_d;
   logic                  order_err_q, order_err_d;
   logic                  wr_lo_acc, wr_hi_acc;
   logic [DATA_WIDTH-1:0] mem_q [2][BYTES];
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  rd_valid_q;
   logic                  wr_ready;
   logic                  frame_valid;

   assign wr_ready    = (state_q[wr_bank_q] != FULL);
   assign frame_valid = (state_q[rd_bank_q] == FULL);

   always_comb begin
      state_d[0]  = state_q[0];
      state_d[1]  = state_q[1];
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      overflow_d  = overflow_q;
      order_err_d = order_err_q;
      wr_lo_acc   = 1'b0;
      wr_hi_acc   = 1'b0;

      if (bus.wr_lo_en_i || bus.wr_hi_en_i) begin
         if (!wr_ready) begin
            overflow_d = 1'b1;
         end else if (bus.wr_lo_en_i && bus.wr_hi_en_i) begin
            wr_lo_acc          = 1'b1;
            wr_hi_acc          = 1'b1;
            state_d[wr_bank_q] = FULL;
            wr_bank_d          = ~wr_bank_q;
         end else if (bus.wr_lo_en_i) begin
            wr_lo_acc          = 1'b1;
            state_d[wr_bank_q] = HALF;
         end else if (state_q[wr_bank_q] == HALF) begin
            wr_hi_acc          = 1'b1;
            state_d[wr_bank_q] = FULL;
            wr_bank_d          = ~wr_bank_q;
         end else begin
            order_err_d = 1'b1;
         end
      end

      // A release only happens on a FULL read bank. The write bank can only
      // coincide with it when both are FULL, in which case the write above
      // was already dropped, so the two updates never touch the same bank.
      if (bus.rd_release_i && frame_valid) begin
         state_d[rd_bank_q] = EMPTY;
         rd_bank_d          = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q[0]  <= EMPTY;
         state_q[1]  <= EMPTY;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         overflow_q  <= 1'b0;
         order_err_q <= 1'b0;
         dout_q      <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q[0]  <= state_d[0];
         state_q[1]  <= state_d[1];
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         overflow_q  <= overflow_d;
         order_err_q <= order_err_d;
         rd_valid_q  <= bus.rd_en_i && frame_valid;
         if (bus.rd_en_i && frame_valid) begin
            dout_q <= mem_q[rd_bank_q][bus.rd_addr_i];
         end
      end
   end

   // Frame storage is never reset; the bank state decides what is valid.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int k = 0; k < LANES; k++) begin
            if (wr_lo_acc) mem_q[wr_bank_q][k]         <= bus.din_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (wr_hi_acc) mem_q[wr_bank_q][k + LANES] <= bus.din_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign bus.wr_ready_o    = wr_ready;
   assign bus.frame_valid_o = frame_valid;
   assign bus.dout_o        = dout_q;
   assign bus.rd_valid_o    = rd_valid_q;
   assign bus.overflow_o    = overflow_q;
   assign bus.order_err_o   = order_err_q;
endmodule
